// File: rtl/instr_encoder.sv
// RV32 instruction encoder: builds a 32-bit word from format/fields/immediate,
// range-checks the immediate and queues {err, instr} in a 2-entry FIFO.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        imm12_ok, immb_ok, immu_ok, immj_ok;

  logic [32:0] mem_q [2];
  logic [32:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        ready_en_q, ready_en_d;
  logic        push, pop;
  logic [32:0] head;

  // A value fits a signed N-bit field when every bit above the sign bit copies it.
  always_comb begin
    imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    immb_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    immu_ok  = ~(|in_imm[11:0]);
    immj_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  end

  always_comb begin
    enc_instr = 32'h0000_0013;
    enc_err   = 1'b1;
    case (in_fmt)
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      FMT_I: if (imm12_ok) begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      FMT_S: if (imm12_ok) begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = 1'b0;
      end
      FMT_B: if (immb_ok) begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = 1'b0;
      end
      FMT_U: if (immu_ok) begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      FMT_J: if (immj_ok) begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      default: begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b1;
      end
    endcase
  end

  // in_ready is held low until the first edge after reset release.
  assign in_ready  = ready_en_q & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head[31:0] : '0;
  assign out_err   = out_valid ? head[32] : 1'b0;
  assign err_count = err_count_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    count_d     = count_q;
    err_count_d = err_count_q;
    ready_en_d  = 1'b1;
    if (push) mem_d[wr_ptr_q] = {enc_err, enc_instr};
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push && enc_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      err_count_q <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
      ready_en_q  <= ready_en_d;
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset, asserted async, deasserted sync to clk.
REQ-003 in_valid  input  1  request word present.
REQ-004 in_ready  output  1  encoder can accept; high when FIFO count < 2.
REQ-005 in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-006 in_opcode  input  7  placed in bits [6:0].
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_funct3  input  3 / in_funct7  input  7  function fields.
REQ-009 in_imm  input  32  signed byte-offset/immediate value (same numeric value the decode side reproduces).
REQ-010 out_valid  output  1  FIFO head holds a word.
REQ-011 out_ready  input  1  consumer takes head.
REQ-012 out_instr  output  32  encoded instruction at head.
REQ-013 out_err  output  1  head word was rejected (range/format error).
REQ-014 err_count  output  8  saturating count of rejected requests.

Function
REQ-015 Transfer in: in_valid && in_ready at rising edge; transfer out: out_valid && out_ready.
REQ-016 Encoding combinational from inputs, result written into 2-entry FIFO in accept cycle; accepted at edge N -> out_valid=1 after edge N when FIFO was empty (latency 1).
REQ-017 R: {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored, never errors.
REQ-018 I: {imm[11:0], rs1, funct3, rd, opcode}; legal iff -2048 <= imm <= 2047.
REQ-019 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; legal range as I.
REQ-020 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; legal iff -4096 <= imm <= 4094 and imm[0]=0.
REQ-021 U: {imm[31:12], rd, opcode}; legal iff imm[11:0]=0.
REQ-022 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; legal iff -1048576 <= imm <= 1048574 and imm[0]=0.
REQ-023 Range checks are signed 32-bit: bits above the field's sign bit must all equal that sign bit.
REQ-024 Illegal fmt (6/7) or failed range check: pushed word = 32'h00000013 (NOP) with err flag 1; otherwise err flag 0.
REQ-025 FIFO stores {err, instr} per entry, in-order; out_instr/out_err = head entry; both 0 when empty.
REQ-026 Full (count=2): in_ready=0, no push; pop on that edge -> in_ready=1 next cycle (no same-cycle pass-through).
REQ-027 Count<2 with simultaneous push and pop: count unchanged, order preserved.
REQ-028 Empty: out_valid=0; out_ready ignored, no underflow.
REQ-029 err_count increments by 1 per accepted erroneous request, at accept edge; holds at 255.
REQ-030 Inputs sampled only on accepting edge; changes while in_ready=0 have no effect.

Reset
REQ-031 rst_n low: immediately out_valid=0, out_instr=0, out_err=0, err_count=0, FIFO count=0, in_ready=0.
REQ-032 in_ready=1 from first rising edge after rst_n high.
REQ-033 Reset mid-operation discards all FIFO contents; no partial word delivered afterwards.

Verification
REQ-034 I fmt, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> out_instr=0x00500093, out_err=0, out_valid one cycle after accept.
REQ-035 S opcode 0x23, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423; B opcode 0x63, rs1=rs2=0, funct3=0, imm=-4 -> 0xFE000EE3; U opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-036 Errors: I imm=2048, B imm=3, U imm=0x00001001, fmt=7 -> each out_instr=0x00000013, out_err=1; err_count=4; 256+ errors -> err_count=255.
REQ-037 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 on third; raise out_ready -> words emerge in order, third accepted cycle after first pop.
REQ-038 FIFO holding 2 words, pulse rst_n low mid-cycle -> out_valid drops immediately, err_count=0, no stale word after release.
